logic_op_scheduler: RTL and testbench
=====================================

Name: logic_op_scheduler

Overview:
Shares one ap_ctrl_hs logic-operation kernel between NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's operands and opcode.
- Sequences the kernel's ap_start/ap_ready/ap_done handshake and routes the result back to the requester.
- Sits between the requester fabric and the kernel instance; one transaction is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 3, opcode width
TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
req_a  in  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  packed operand B
req_op  in  NUM_REQ*OP_W  packed opcode
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  requester index of response
rsp_data  out  DATA_W  kernel result
rsp_err  out  1  timeout flag (0 without feature)
k_a, k_b  out  DATA_W  kernel operands
k_op  out  OP_W  kernel opcode
ap_start  out  1  kernel start
ap_ready  in  1  kernel accepted inputs
ap_done  in  1  kernel result valid
k_result  in  DATA_W  kernel result
busy  out  1  transaction in flight
txn_count  out  32  completed transactions, wraps at 2^32

Behaviour:
- Reset (async, ap_rst_n=0): all outputs 0; FSM=IDLE; rr pointer=0; txn_count=0. Reset mid-transaction abandons it with no response; the kernel shares the reset.
- States:
  - IDLE: if any req_valid is set, grant the first set bit at or after the rr pointer (cyclic). Assert req_ready[winner] combinationally in IDLE only. On the accepting edge: latch a/b/op/id; rr pointer = winner+1 mod NUM_REQ; go to START.
  - START: ap_start=1 with k_a/k_b/k_op driven from the latches. ap_start stays high until ap_ready is sampled 1.
    - ap_ready and ap_done both 1 (zero-latency kernel): capture k_result, go to RESP.
    - ap_ready only: go to WAIT.
  - WAIT: ap_start=0. On ap_done=1, capture k_result and go to RESP.
  - RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err stable until rsp_ready. On the handshake: txn_count+1, go to IDLE.
- busy=1 in every state except IDLE.
- Latency from accept to rsp_valid: kernel latency + 1 cycle minimum. Accept to next accept: at least 3 cycles (START, RESP, IDLE).
- ap_done seen outside START/WAIT is ignored.
- Requests are never accepted while not in IDLE.
- A requester dropping req_valid before its grant loses nothing; arbitration re-evaluates every IDLE cycle.
- k_a/k_b/k_op hold their last latched values outside START.
- txn_count wraps from 0xFFFFFFFF to 0.

Optional Feature:
LOGIC_OP_SCHED_TIMEOUT_EN
- Defined: a cycle counter runs in START/WAIT. If it reaches TIMEOUT_CYC without completion, go to RESP with rsp_err=1 and rsp_data=0. The counter clears on every state entry. txn_count still increments.
- Undefined: no counter; rsp_err tied 0; the scheduler waits indefinitely.

Test Plan:
- Single request: req_valid[2]=1, a=0xF0F0F0F0, b=0x0FF00FF0, op=AND, kernel latency 1 -> rsp_id=2, rsp_data=0x00F000F0, txn_count=1.
- Fairness: all four req_valid held high for 8 transactions starting from reset -> grant order 0,1,2,3,0,1,2,3; one req_ready bit per accept.
- Zero-latency kernel: ap_ready and ap_done in the same cycle as ap_start -> no WAIT cycle, rsp_valid on the next cycle, ap_start high for exactly 1 cycle.
- Backpressure: rsp_ready=0 for 10 cycles with a new req_valid pending -> rsp held stable, no req_ready, no ap_start until the response handshake.
- Reset mid-WAIT: drop ap_rst_n -> ap_start, rsp_valid, busy and txn_count read 0 immediately; after release, the next request completes normally with rr pointer 0.
- With LOGIC_OP_SCHED_TIMEOUT_EN and TIMEOUT_CYC=16, kernel never asserts ap_done -> rsp_valid with rsp_err=1 and rsp_data=0 within 16 cycles of the first wait cycle after ap_ready; the next request is accepted.

Source files
------------

// File: rtl/logic_op_scheduler.sv
// Shares one ap_ctrl_hs logic-op kernel between NUM_REQ requesters; optional watchdog via LOGIC_OP_SCHED_TIMEOUT_EN.
// Latency: accept -> rsp_valid is kernel latency + 1 cycle minimum; accept -> next accept at least 3 cycles.
// Backpressure: a stalled response (rsp_ready=0) holds the response and blocks all new grants and ap_start.
module logic_op_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*OP_W-1:0]     req_op,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           k_a,
  output logic [DATA_W-1:0]           k_b,
  output logic [OP_W-1:0]             k_op,
  output logic                        ap_start,
  input  logic                        ap_ready,
  input  logic                        ap_done,
  input  logic [DATA_W-1:0]           k_result,
  output logic                        busy,
  output logic [31:0]                 txn_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [ID_W-1:0]   id;
  } txn_t;

  state_t            state;
  txn_t              txn_q;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_next;
  logic              grant_any;
  logic [DATA_W-1:0] result_q;

  // Round-robin: first asserted request at or after rr_ptr, wrapping cyclically.
  always_comb begin
    int idx;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end

  assign rr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign req_ready = (ap_rst_n && state == IDLE && grant_any) ?
                     (NUM_REQ'(1) << grant_id) : '0;

  assign k_a      = txn_q.a;
  assign k_b      = txn_q.b;
  assign k_op     = txn_q.op;
  assign rsp_id   = txn_q.id;
  assign rsp_data = result_q;

`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            err_q;
  logic            to_hit;
  assign to_hit  = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      txn_q     <= '0;
      result_q  <= '0;
      ap_start  <= 1'b0;
      rsp_valid <= 1'b0;
      busy      <= 1'b0;
      txn_count <= '0;
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
      to_cnt <= (state == START || state == WAIT) ? to_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: begin
          if (grant_any) begin
            txn_q.a  <= req_a[grant_id*DATA_W +: DATA_W];
            txn_q.b  <= req_b[grant_id*DATA_W +: DATA_W];
            txn_q.op <= req_op[grant_id*OP_W +: OP_W];
            txn_q.id <= grant_id;
            rr_ptr   <= rr_next;
            ap_start <= 1'b1;
            busy     <= 1'b1;
            state    <= START;
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
            to_cnt   <= '0;
`endif
          end
        end
        START: begin
          if (ap_ready) begin
            ap_start <= 1'b0;
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
            to_cnt   <= '0;
`endif
            // Zero-latency kernel: result is already valid alongside ap_ready.
            if (ap_done) begin
              result_q  <= k_result;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              state     <= WAIT;
            end
          end
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            ap_start  <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`endif
        end
        WAIT: begin
          if (ap_done) begin
            result_q  <= k_result;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
          else if (to_hit) begin
            result_q  <= '0;
            err_q     <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            txn_count <= txn_count + 32'd1;
            state     <= IDLE;
`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler with a behavioural ap_ctrl_hs kernel of configurable latency.
module tb_logic_op_scheduler;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int OW = 3;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a = '0;
  logic [NR*DW-1:0]  req_b = '0;
  logic [NR*OW-1:0]  req_op = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  logic [DW-1:0]     k_a, k_b;
  logic [OW-1:0]     k_op;
  logic              ap_start;
  logic              ap_ready = 1'b0;
  logic              ap_done = 1'b0;
  logic [DW-1:0]     k_result = '0;
  logic              busy;
  logic [31:0]       txn_count;

  always #5 ap_clk = ~ap_clk;

  logic_op_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW), .TIMEOUT_CYC(16)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .k_a(k_a), .k_b(k_b), .k_op(k_op),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .k_result(k_result),
    .busy(busy), .txn_count(txn_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Kernel model: 0 AND, 1 OR, 2 XOR, other NAND.
  function automatic logic [DW-1:0] kop(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'd0:    kop = a & b;
      3'd1:    kop = a | b;
      3'd2:    kop = a ^ b;
      default: kop = ~(a & b);
    endcase
  endfunction

  int          k_lat  = 1;
  bit          k_zero = 1'b0;
  int          k_cnt  = 0;
  logic [DW-1:0] k_hold = '0;

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      ap_ready = 1'b0; ap_done = 1'b0; k_cnt = 0; k_result = '0;
    end else begin
      ap_ready = 1'b0;
      ap_done  = 1'b0;
      if (k_cnt > 0) begin
        k_cnt--;
        if (k_cnt == 0) begin ap_done = 1'b1; k_result = k_hold; end
      end
      if (ap_start) begin
        ap_ready = 1'b1;
        if (k_zero) begin
          ap_done = 1'b1; k_result = kop(k_op, k_a, k_b);
        end else begin
          k_hold = kop(k_op, k_a, k_b); k_cnt = k_lat;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_op[i*OW +: OW] = op;
  endtask

  task automatic wait_rsp(input string tag);
    int k = 0;
    while (!rsp_valid && k < 50) begin @(negedge ap_clk); k++; end
    check({tag, "_rsp_vld"}, rsp_valid, 1'b1);
  endtask

  task automatic take_rsp(input string tag, input int id, input logic [DW-1:0] data);
    wait_rsp(tag);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_data"}, rsp_data, data);
    check({tag, "_err"}, rsp_err, 1'b0);
    rsp_ready = 1'b1;
    @(posedge ap_clk); @(negedge ap_clk);
    rsp_ready = 1'b0;
  endtask

  // Drives req_valid, checks the combinational grant, accepts on the next edge.
  task automatic issue(input string tag, input logic [NR-1:0] vld, input logic [NR-1:0] exp_rdy);
    req_valid = vld;
    #1;
    check({tag, "_grant"}, req_ready, exp_rdy);
    @(posedge ap_clk); @(negedge ap_clk);
    req_valid = '0;
  endtask

  logic [DW-1:0] fair_exp [4] = '{32'h0F000F00, 32'hFF0FFF0F, 32'hF00FF00F, 32'hF0FFF0FF};

  initial begin
    // Reset state, with requests present to confirm no grant leaks out.
    req_valid = 4'hF;
    repeat (2) @(negedge ap_clk);
    #1;
    check("rst_ready", req_ready, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", ap_start, 1'b0);
    check("rst_rsp_vld", rsp_valid, 1'b0);
    check("rst_count", txn_count, 32'd0);
    check("rst_err", rsp_err, 1'b0);
    req_valid = '0;
    ap_rst_n  = 1'b1;
    @(negedge ap_clk);

    // Single request, AND, latency 1.
    set_req(2, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd0);
    issue("t1", 4'b0100, 4'b0100);
    check("t1_start", ap_start, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_ka", k_a, 32'hF0F0F0F0);
    check("t1_kb", k_b, 32'h0FF00FF0);
    check("t1_kop", k_op, 3'd0);
    take_rsp("t1", 2, 32'h00F000F0);
    check("t1_count", txn_count, 32'd1);
    check("t1_idle", busy, 1'b0);

    // Fairness from reset with all requesters always valid.
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 32'hFF00FF00, 32'h0F0F0F0F, OW'(i));
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int t = 0; t < 8; t++) begin
      int g = 0;
      #1;
      while (req_ready == '0 && g < 10) begin @(negedge ap_clk); #1; g++; end
      check("fair_grant", req_ready, 4'b0001 << (t % 4));
      @(posedge ap_clk); @(negedge ap_clk);
      wait_rsp("fair");
      check("fair_id", rsp_id, t % 4);
      check("fair_data", rsp_data, fair_exp[t % 4]);
      @(posedge ap_clk); @(negedge ap_clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    check("fair_count", txn_count, 32'd8);

    // Zero-latency kernel: no WAIT, one-cycle ap_start.
    k_zero = 1'b1;
    set_req(1, 32'h12345678, 32'hFFFF0000, 3'd2);
    issue("zl", 4'b0010, 4'b0010);
    check("zl_start", ap_start, 1'b1);
    @(negedge ap_clk);
    check("zl_start_low", ap_start, 1'b0);
    check("zl_rsp_vld", rsp_valid, 1'b1);
    check("zl_id", rsp_id, 1);
    check("zl_data", rsp_data, 32'hEDCB5678);
    rsp_ready = 1'b1;
    @(posedge ap_clk); @(negedge ap_clk);
    rsp_ready = 1'b0;
    k_zero = 1'b0;

    // Response backpressure with another request pending.
    set_req(0, 32'hAAAA5555, 32'h0000FFFF, 3'd1);
    issue("bp", 4'b0001, 4'b0001);
    wait_rsp("bp");
    check("bp_data", rsp_data, 32'hAAAAFFFF);
    set_req(3, 32'h0000FFFF, 32'h00FF00FF, 3'd0);
    req_valid = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      #1;
      check("bp_hold_vld", rsp_valid, 1'b1);
      check("bp_hold_data", rsp_data, 32'hAAAAFFFF);
      check("bp_hold_id", rsp_id, 0);
      check("bp_no_ready", req_ready, 4'h0);
      check("bp_no_start", ap_start, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge ap_clk); @(negedge ap_clk);
    rsp_ready = 1'b0;
    issue("bp2", 4'b1000, 4'b1000);
    take_rsp("bp2", 3, 32'h000000FF);
    check("bp_count", txn_count, 32'd11);

    // Reset while waiting on the kernel.
    k_lat = 1000;
    set_req(2, 32'h1, 32'h1, 3'd0);
    issue("rw", 4'b0100, 4'b0100);
    @(negedge ap_clk);
    check("rw_wait_busy", busy, 1'b1);
    check("rw_wait_start", ap_start, 1'b0);
    check("rw_wait_rsp", rsp_valid, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    check("rw_rst_start", ap_start, 1'b0);
    check("rw_rst_rsp", rsp_valid, 1'b0);
    check("rw_rst_busy", busy, 1'b0);
    check("rw_rst_count", txn_count, 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    k_lat = 1;
    set_req(2, 32'hCAFEF00D, 32'hFFFF0000, 3'd0);
    set_req(3, 32'h0, 32'h0, 3'd1);
    issue("rw_ptr", 4'b1100, 4'b0100);
    take_rsp("rw", 2, 32'hCAFE0000);
    check("rw_count", txn_count, 32'd1);

`ifdef LOGIC_OP_SCHED_TIMEOUT_EN
    // Kernel accepts but never completes: watchdog closes the transaction.
    k_lat = 100000;
    set_req(0, 32'h5, 32'h5, 3'd0);
    issue("to", 4'b0001, 4'b0001);
    @(negedge ap_clk);
    begin
      int k = 0;
      while (!rsp_valid && k < 16) begin @(negedge ap_clk); k++; end
    end
    check("to_rsp_vld", rsp_valid, 1'b1);
    check("to_err", rsp_err, 1'b1);
    check("to_data", rsp_data, 32'h0);
    check("to_id", rsp_id, 0);
    rsp_ready = 1'b1;
    @(posedge ap_clk); @(negedge ap_clk);
    rsp_ready = 1'b0;
    k_lat = 1;
    set_req(1, 32'hFFFFFFFF, 32'h0000FFFF, 3'd0);
    issue("to_next", 4'b0010, 4'b0010);
    take_rsp("to_next", 1, 32'h0000FFFF);
    check("to_count", txn_count, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
